// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - stall bus encodings, stall vector constants and divider FSM states
package pipe_stall_ctrl_pkg;

    localparam int STALL_W = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Bit k holds pipeline register k: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB
    localparam logic [STALL_W-1:0] STALL_NONE = {STALL_W{NO_STOP}};
    localparam logic [STALL_W-1:0] STALL_ID   = {NO_STOP, NO_STOP, NO_STOP, STOP, STOP, STOP};
    localparam logic [STALL_W-1:0] STALL_EX   = {NO_STOP, NO_STOP, STOP, STOP, STOP, STOP};
    localparam logic [STALL_W-1:0] STALL_MEM  = {NO_STOP, STOP, STOP, STOP, STOP, STOP};

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_div_seq_fsm.sv
// rtl/pipe_stall_ctrl_div_seq_fsm.sv - divider start/ready handshake FSM and cycle counter
// PIPE_STALL_CTRL_DIV_TIMEOUT_EN adds a sticky timeout after DIV_MAX busy cycles.
module pipe_stall_ctrl_div_seq_fsm
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 6
`ifdef PIPE_STALL_CTRL_DIV_TIMEOUT_EN
    ,
    parameter int DIV_MAX = 40
`endif
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_req,
    input  logic             div_ready,
    input  logic             flush_req,
    input  logic             stallreq_mem,
    output div_state_t       state,
    output logic             div_start,
    output logic             div_cancel,
    output logic [CNT_W-1:0] div_cycles
`ifdef PIPE_STALL_CTRL_DIV_TIMEOUT_EN
    ,
    output logic             div_timeout
`endif
);

    div_state_t state_q;
    div_state_t state_d;

`ifdef PIPE_STALL_CTRL_DIV_TIMEOUT_EN
    logic timeout_hit;
    logic timeout_q;
`endif

    always_comb begin
        state_d    = state_q;
        div_start  = 1'b0;
        div_cancel = 1'b0;
`ifdef PIPE_STALL_CTRL_DIV_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (div_req && !flush_req) begin
                    div_start = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                // Flush beats a coincident div_ready: the result is dropped.
                if (flush_req) begin
                    div_cancel = 1'b1;
                    state_d    = IDLE;
                end else if (div_ready) begin
                    state_d = DONE;
                end
`ifdef PIPE_STALL_CTRL_DIV_TIMEOUT_EN
                else if (div_cycles == CNT_W'(DIV_MAX)) begin
                    timeout_hit = 1'b1;
                    div_cancel  = 1'b1;
                    state_d     = DONE;
                end
`endif
            end
            DONE: begin
                if (flush_req) begin
                    div_cancel = 1'b1;
                    state_d    = IDLE;
                end else if (!stallreq_mem) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The divider shares resetn, so no pulses are sent to it during reset.
        if (!resetn) begin
            div_start  = 1'b0;
            div_cancel = 1'b0;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            div_cycles <= '0;
        end else begin
            state_q <= state_d;
            if (div_start || (flush_req && state_q != IDLE)) begin
                div_cycles <= '0;
            end else if (state_q == BUSY && div_cycles != '1) begin
                div_cycles <= div_cycles + CNT_W'(1);
            end
        end
    end

`ifdef PIPE_STALL_CTRL_DIV_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            timeout_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_q <= 1'b1;
        end
    end

    assign div_timeout = timeout_q | timeout_hit;
`endif

    assign state = state_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall priority mux, flush pass-through and divider sequencing
// PIPE_STALL_CTRL_DIV_TIMEOUT_EN adds the div_timeout output and DIV_MAX parameter.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 6
`ifdef PIPE_STALL_CTRL_DIV_TIMEOUT_EN
    ,
    parameter int DIV_MAX = 40
`endif
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               stallreq_id,
    input  logic               stallreq_mem,
    input  logic               div_req,
    input  logic               div_ready,
    input  logic               flush_req,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic               div_start,
    output logic               div_cancel,
    output logic               div_result_valid,
    output logic               div_busy,
    output logic [CNT_W-1:0]   div_cycles
`ifdef PIPE_STALL_CTRL_DIV_TIMEOUT_EN
    ,
    output logic               div_timeout
`endif
);

    div_state_t state;

    pipe_stall_ctrl_div_seq_fsm #(
        .CNT_W       (CNT_W)
`ifdef PIPE_STALL_CTRL_DIV_TIMEOUT_EN
        ,
        .DIV_MAX     (DIV_MAX)
`endif
    ) u_div_seq_fsm (
        .clk         (clk),
        .resetn      (resetn),
        .div_req     (div_req),
        .div_ready   (div_ready),
        .flush_req   (flush_req),
        .stallreq_mem(stallreq_mem),
        .state       (state),
        .div_start   (div_start),
        .div_cancel  (div_cancel),
        .div_cycles  (div_cycles)
`ifdef PIPE_STALL_CTRL_DIV_TIMEOUT_EN
        ,
        .div_timeout (div_timeout)
`endif
    );

    // DONE releases EX so the finished divide advances on the next edge.
    always_comb begin
        stall = STALL_NONE;
        if (!resetn || flush_req) begin
            stall = STALL_NONE;
        end else if (stallreq_mem) begin
            stall = STALL_MEM;
        end else if (state == BUSY || (state == IDLE && div_req)) begin
            stall = STALL_EX;
        end else if (stallreq_id) begin
            stall = STALL_ID;
        end
    end

    assign flush            = resetn && flush_req;
    assign div_result_valid = resetn && state == DONE && !flush_req;
    assign div_busy         = (state == BUSY);

endmodule
